vpu_rr_sched: RTL

VPU_RR_SCHED -- requirements
Module: VPU_RR_SCHED

---
 rtl/vpu_rr_sched.sv | 109 ++++++++++
 1 files changed

// File: rtl/vpu_rr_sched.sv
// rtl/vpu_rr_sched.sv - round-robin arbiter feeding a single shared VPU delay unit
// One operation runs at a time; done_o pulses D edges after the acceptance edge.
module vpu_rr_sched #(
  parameter int NUM_REQ       = 4,
  parameter int MAX_DELAY_LG2 = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [NUM_REQ*MAX_DELAY_LG2-1:0]   req_delay_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic [NUM_REQ-1:0]                 done_o,
  output logic                               busy_o,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int DW  = MAX_DELAY_LG2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [DW-1:0]    dly_q, dly_d;
  logic [DW-1:0]    cntr_q, cntr_d;
  logic [NUM_REQ-1:0] done_q, done_d;

  logic [IDW-1:0]   win;
  logic [IDW-1:0]   cand;
  int               cand_i;
  logic             found;
  logic             accept;
  logic [DW-1:0]    d_eff;

  // Search starts just after the last winner and wraps, so the last winner has lowest priority.
  always_comb begin
    win    = last_q;
    found  = 1'b0;
    cand   = '0;
    cand_i = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_i = int'(last_q) + k;
      if (cand_i >= NUM_REQ) cand_i = cand_i - NUM_REQ;
      cand = IDW'(cand_i);
      if (!found && req_valid_i[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign accept      = rst_n && (state_q == IDLE) && (|req_valid_i);
  assign req_ready_o = accept ? (NUM_REQ'(1) << win) : '0;
  assign d_eff       = (dly_q == '0) ? DW'(1) : dly_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    dly_d   = dly_q;
    cntr_d  = cntr_q;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          last_d  = win;
          gid_d   = win;
          dly_d   = req_delay_i[win*DW +: DW];
          cntr_d  = DW'(1);
        end
      end
      RUN: begin
        if (cntr_q == d_eff) begin
          state_d = IDLE;
          cntr_d  = '0;
          done_d  = NUM_REQ'(1) << gid_q;
        end else begin
          cntr_d  = cntr_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IDW'(NUM_REQ - 1);
      gid_q   <= '0;
      dly_q   <= '0;
      cntr_q  <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      dly_q   <= dly_d;
      cntr_q  <= cntr_d;
      done_q  <= done_d;
    end
  end

  assign done_o     = done_q;
  assign busy_o     = (state_q == RUN);
  assign grant_id_o = gid_q;

endmodule
